// File: rtl/decode_stage.sv
// decode_stage: RV32I(M) instruction decoder feeding a DEPTH-entry output FIFO
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   in_valid, in_ready       instruction handshake; in_inst is the word, in_pc its address
//   flush                    drops every queued entry and any same-cycle input
//   out_valid, out_ready     decoded-bundle handshake; all out-side fields show the FIFO head
//   rs1/rs2/rd _addr, _en    register addresses and enables (rd_en is 0 for x0)
//   imm, b_is_imm, a_is_pc   sign-extended immediate and ALU operand selects
//   ex_operation             1 ADD, 2 SUB, 3 SLL, 4 SLT, 5 SLTU, 6 XOR, 7 SRL, 8 SRA,
//                            9 OR, 10 AND, 11 PASS_B, 0x200|funct3 for MUL..REMU, 0 illegal
//   cmp_op                   funct3, used by the branch comparator
//   is_*, rd_is_link         control-flow / memory class flags
//   mem_size, mem_unsigned   access width (0 byte, 1 half, 2 word) and load zero-extension
//   illegal                  word is not a decodable instruction
module decode_stage #(
    parameter int DEPTH    = 2,
    parameter bit ENABLE_M = 1'b1,
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [PC_WIDTH-1:0] in_pc,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [4:0]          rs1_addr,
    output logic [4:0]          rs2_addr,
    output logic [4:0]          rd_addr,
    output logic                rs1_en,
    output logic                rs2_en,
    output logic                rd_en,
    output logic [31:0]         imm,
    output logic                b_is_imm,
    output logic                a_is_pc,
    output logic [9:0]          ex_operation,
    output logic [2:0]          cmp_op,
    output logic                is_branch,
    output logic                is_jal,
    output logic                is_jalr,
    output logic                rd_is_link,
    output logic                is_load,
    output logic                is_store,
    output logic                mem_unsigned,
    output logic [1:0]          mem_size,
    output logic                illegal
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [9:0] EX_ADD  = 10'd1;
    localparam logic [9:0] EX_SUB  = 10'd2;
    localparam logic [9:0] EX_SLL  = 10'd3;
    localparam logic [9:0] EX_SLT  = 10'd4;
    localparam logic [9:0] EX_SLTU = 10'd5;
    localparam logic [9:0] EX_XOR  = 10'd6;
    localparam logic [9:0] EX_SRL  = 10'd7;
    localparam logic [9:0] EX_SRA  = 10'd8;
    localparam logic [9:0] EX_OR   = 10'd9;
    localparam logic [9:0] EX_AND  = 10'd10;
    localparam logic [9:0] EX_PASS = 10'd11;
    localparam logic [9:0] EX_MDU  = 10'h200;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [4:0]          rs1_addr;
        logic [4:0]          rs2_addr;
        logic [4:0]          rd_addr;
        logic                rs1_en;
        logic                rs2_en;
        logic                rd_en;
        logic [31:0]         imm;
        logic                b_is_imm;
        logic                a_is_pc;
        logic [9:0]          ex_operation;
        logic [2:0]          cmp_op;
        logic                is_branch;
        logic                is_jal;
        logic                is_jalr;
        logic                rd_is_link;
        logic                is_load;
        logic                is_store;
        logic                mem_unsigned;
        logic [1:0]          mem_size;
        logic                illegal;
    } bundle_t;

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        legal, is_m;
    bundle_t     raw, dec;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];
    assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u  = {in_inst[31:12], 12'b0};
    assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    // alt selects SUB/SRA; it is only meaningful for funct3 0 and 5
    function automatic logic [9:0] alu_op(input logic [2:0] f, input logic alt);
        case (f)
            3'd0:    alu_op = alt ? EX_SUB : EX_ADD;
            3'd1:    alu_op = EX_SLL;
            3'd2:    alu_op = EX_SLT;
            3'd3:    alu_op = EX_SLTU;
            3'd4:    alu_op = EX_XOR;
            3'd5:    alu_op = alt ? EX_SRA : EX_SRL;
            3'd6:    alu_op = EX_OR;
            default: alu_op = EX_AND;
        endcase
    endfunction

    // The full 7-bit opcode includes inst[1:0], so non-32-bit encodings fall to default.
    always_comb begin
        raw          = '0;
        raw.pc       = in_pc;
        raw.rs1_addr = in_inst[19:15];
        raw.rs2_addr = in_inst[24:20];
        raw.rd_addr  = in_inst[11:7];
        raw.cmp_op   = f3;
        legal        = 1'b0;
        is_m         = f7 == 7'h01;
        case (opcode)
            OPC_LOAD: begin
                legal            = (f3[1:0] != 2'b11) && !(f3[2] && f3[1]);
                raw.rs1_en       = 1'b1;
                raw.rd_en        = 1'b1;
                raw.b_is_imm     = 1'b1;
                raw.is_load      = 1'b1;
                raw.mem_size     = f3[1:0];
                raw.mem_unsigned = f3[2];
                raw.imm          = imm_i;
                raw.ex_operation = EX_ADD;
            end
            OPC_STORE: begin
                legal            = !f3[2] && (f3[1:0] != 2'b11);
                raw.rs1_en       = 1'b1;
                raw.rs2_en       = 1'b1;
                raw.b_is_imm     = 1'b1;
                raw.is_store     = 1'b1;
                raw.mem_size     = f3[1:0];
                raw.imm          = imm_s;
                raw.ex_operation = EX_ADD;
            end
            OPC_OP_IMM: begin
                legal            = (f3 == 3'd1) ? (f7 == 7'h00) :
                                   (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
                raw.rs1_en       = 1'b1;
                raw.rd_en        = 1'b1;
                raw.b_is_imm     = 1'b1;
                // funct3 1 and 5 are the shifts: immediate is the bare shamt
                raw.imm          = (f3[1:0] == 2'b01) ? {27'b0, in_inst[24:20]} : imm_i;
                raw.ex_operation = alu_op(f3, (f3 == 3'd5) && f7[5]);
            end
            OPC_OP: begin
                legal            = (f7 == 7'h00) ||
                                   (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) ||
                                   (is_m && ENABLE_M);
                raw.rs1_en       = 1'b1;
                raw.rs2_en       = 1'b1;
                raw.rd_en        = 1'b1;
                raw.ex_operation = is_m ? (EX_MDU | {7'b0, f3}) : alu_op(f3, f7[5]);
            end
            OPC_LUI: begin
                legal            = 1'b1;
                raw.rd_en        = 1'b1;
                raw.b_is_imm     = 1'b1;
                raw.imm          = imm_u;
                raw.ex_operation = EX_PASS;
            end
            OPC_AUIPC: begin
                legal            = 1'b1;
                raw.rd_en        = 1'b1;
                raw.a_is_pc      = 1'b1;
                raw.b_is_imm     = 1'b1;
                raw.imm          = imm_u;
                raw.ex_operation = EX_ADD;
            end
            OPC_JAL: begin
                legal            = 1'b1;
                raw.rd_en        = 1'b1;
                raw.is_jal       = 1'b1;
                raw.a_is_pc      = 1'b1;
                raw.b_is_imm     = 1'b1;
                raw.rd_is_link   = 1'b1;
                raw.imm          = imm_j;
                raw.ex_operation = EX_ADD;
            end
            OPC_JALR: begin
                legal            = f3 == 3'd0;
                raw.rs1_en       = 1'b1;
                raw.rd_en        = 1'b1;
                raw.is_jalr      = 1'b1;
                raw.rd_is_link   = 1'b1;
                raw.b_is_imm     = 1'b1;
                raw.imm          = imm_i;
                raw.ex_operation = EX_ADD;
            end
            OPC_BRANCH: begin
                legal            = f3[2:1] != 2'b01;
                raw.rs1_en       = 1'b1;
                raw.rs2_en       = 1'b1;
                raw.is_branch    = 1'b1;
                raw.a_is_pc      = 1'b1;
                raw.b_is_imm     = 1'b1;
                raw.imm          = imm_b;
                raw.ex_operation = EX_ADD;
            end
            default: legal = 1'b0;
        endcase
        raw.rd_en = raw.rd_en && (raw.rd_addr != 5'd0);
        dec = raw;
        // illegal words keep only pc, register fields and cmp_op
        if (!legal) begin
            dec          = '0;
            dec.pc       = in_pc;
            dec.rs1_addr = raw.rs1_addr;
            dec.rs2_addr = raw.rs2_addr;
            dec.rd_addr  = raw.rd_addr;
            dec.cmp_op   = f3;
            dec.illegal  = 1'b1;
        end
    end

    bundle_t        mem [DEPTH];
    bundle_t        head;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           push, pop;

    assign in_ready  = !rst && (count < CW'(DEPTH));
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    // masking with out_valid keeps the bundle at zero while empty or in reset
    assign head         = out_valid ? mem[rd_ptr] : '0;
    assign out_pc       = head.pc;
    assign rs1_addr     = head.rs1_addr;
    assign rs2_addr     = head.rs2_addr;
    assign rd_addr      = head.rd_addr;
    assign rs1_en       = head.rs1_en;
    assign rs2_en       = head.rs2_en;
    assign rd_en        = head.rd_en;
    assign imm          = head.imm;
    assign b_is_imm     = head.b_is_imm;
    assign a_is_pc      = head.a_is_pc;
    assign ex_operation = head.ex_operation;
    assign cmp_op       = head.cmp_op;
    assign is_branch    = head.is_branch;
    assign is_jal       = head.is_jal;
    assign is_jalr      = head.is_jalr;
    assign rd_is_link   = head.rd_is_link;
    assign is_load      = head.is_load;
    assign is_store     = head.is_store;
    assign mem_unsigned = head.mem_unsigned;
    assign mem_size     = head.mem_size;
    assign illegal      = head.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage (M enabled and M disabled side by side)
module tb_decode_stage;
    localparam int DEPTH = 2;
    localparam logic [6:0] OPS [9] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F};

    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] in_inst = '0, in_pc = '0;

    logic in_ready, out_valid, rs1_en, rs2_en, rd_en, b_is_imm, a_is_pc;
    logic is_branch, is_jal, is_jalr, rd_is_link, is_load, is_store, mem_unsigned, illegal;
    logic [31:0] out_pc, imm;
    logic [4:0] rs1_addr, rs2_addr, rd_addr;
    logic [9:0] ex_operation;
    logic [2:0] cmp_op;
    logic [1:0] mem_size;

    logic m0_in_ready, m0_out_valid, m0_rs1_en, m0_rs2_en, m0_rd_en, m0_b_is_imm, m0_a_is_pc;
    logic m0_is_branch, m0_is_jal, m0_is_jalr, m0_rd_is_link, m0_is_load, m0_is_store, m0_mem_unsigned, m0_illegal;
    logic [31:0] m0_out_pc, m0_imm;
    logic [4:0] m0_rs1_addr, m0_rs2_addr, m0_rd_addr;
    logic [9:0] m0_ex_operation;
    logic [2:0] m0_cmp_op;
    logic [1:0] m0_mem_size;

    decode_stage #(.DEPTH(DEPTH), .ENABLE_M(1'b1), .PC_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_en(rs1_en), .rs2_en(rs2_en), .rd_en(rd_en), .imm(imm), .b_is_imm(b_is_imm), .a_is_pc(a_is_pc),
        .ex_operation(ex_operation), .cmp_op(cmp_op), .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .rd_is_link(rd_is_link), .is_load(is_load), .is_store(is_store), .mem_unsigned(mem_unsigned),
        .mem_size(mem_size), .illegal(illegal));

    decode_stage #(.DEPTH(DEPTH), .ENABLE_M(1'b0), .PC_WIDTH(32)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m0_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .flush(flush), .out_valid(m0_out_valid), .out_ready(out_ready), .out_pc(m0_out_pc),
        .rs1_addr(m0_rs1_addr), .rs2_addr(m0_rs2_addr), .rd_addr(m0_rd_addr),
        .rs1_en(m0_rs1_en), .rs2_en(m0_rs2_en), .rd_en(m0_rd_en), .imm(m0_imm), .b_is_imm(m0_b_is_imm),
        .a_is_pc(m0_a_is_pc), .ex_operation(m0_ex_operation), .cmp_op(m0_cmp_op), .is_branch(m0_is_branch),
        .is_jal(m0_is_jal), .is_jalr(m0_is_jalr), .rd_is_link(m0_rd_is_link), .is_load(m0_is_load),
        .is_store(m0_is_store), .mem_unsigned(m0_mem_unsigned), .mem_size(m0_mem_size), .illegal(m0_illegal));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, imm, ex, m0_ex;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  cmp;
        logic [1:0]  msz;
        logic rs1_en, rs2_en, rd_en, b_imm, a_pc, br, jal, jalr, link, ld, st, mu, ill, m0_ill, m0_rd_en;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the ISA tables; ALU codes follow the team encoding
    function automatic exp_t dec(input logic [31:0] i, input bit m);
        exp_t e;
        int tab [8] = '{1, 3, 4, 5, 6, 7, 9, 10};
        int f3 = int'(i[14:12]);
        int f7 = int'(i[31:25]);
        int op = int'(i[6:0]);
        int si = $signed(i) >>> 20;
        int bi = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        int ji = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
        bit ok = 1'b1;
        e = '{default: '0};
        e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7]; e.cmp = i[14:12];
        if (op == 'h03 && f3 != 3 && f3 < 6) begin
            e.rs1_en = 1; e.rd_en = 1; e.b_imm = 1; e.ld = 1;
            e.msz = 2'(f3 % 4); e.mu = f3 >= 4; e.imm = 32'(si); e.ex = 1;
        end else if (op == 'h23 && f3 <= 2) begin
            e.rs1_en = 1; e.rs2_en = 1; e.b_imm = 1; e.st = 1;
            e.msz = 2'(f3); e.imm = 32'((si & ~31) | int'(i[11:7])); e.ex = 1;
        end else if (op == 'h13 && (f3 == 1 ? f7 == 0 : f3 == 5 ? (f7 == 0 || f7 == 32) : 1'b1)) begin
            e.rs1_en = 1; e.rd_en = 1; e.b_imm = 1;
            e.imm = (f3 == 1 || f3 == 5) ? 32'(i[24:20]) : 32'(si);
            e.ex = (f3 == 5 && f7 == 32) ? 8 : 32'(tab[f3]);
        end else if (op == 'h33 && (f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)) || (f7 == 1 && m))) begin
            e.rs1_en = 1; e.rs2_en = 1; e.rd_en = 1;
            e.ex = f7 == 1 ? 32'(512 + f3) : f7 == 32 ? (f3 == 0 ? 2 : 8) : 32'(tab[f3]);
        end else if (op == 'h37) begin
            e.rd_en = 1; e.b_imm = 1; e.imm = i & 32'hFFFFF000; e.ex = 11;
        end else if (op == 'h17) begin
            e.rd_en = 1; e.a_pc = 1; e.b_imm = 1; e.imm = i & 32'hFFFFF000; e.ex = 1;
        end else if (op == 'h6F) begin
            e.rd_en = 1; e.jal = 1; e.a_pc = 1; e.b_imm = 1; e.link = 1; e.imm = 32'(ji); e.ex = 1;
        end else if (op == 'h67 && f3 == 0) begin
            e.rs1_en = 1; e.rd_en = 1; e.jalr = 1; e.link = 1; e.b_imm = 1; e.imm = 32'(si); e.ex = 1;
        end else if (op == 'h63 && f3 != 2 && f3 != 3) begin
            e.rs1_en = 1; e.rs2_en = 1; e.br = 1; e.a_pc = 1; e.b_imm = 1; e.imm = 32'(bi); e.ex = 1;
        end else ok = 1'b0;
        if (e.rd == 0) e.rd_en = 0;
        e.ill = !ok;
        return e;
    endfunction

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] p);
        exp_t e = dec(i, 1'b1);
        exp_t z = dec(i, 1'b0);
        e.pc = p; e.m0_ill = z.ill; e.m0_rd_en = z.rd_en; e.m0_ex = z.ex;
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 11);
        int s = $urandom_range(0, 3);
        if (k < 9) w[6:0] = OPS[k];
        if (k == 11) begin w[6:0] = OPS[$urandom_range(0, 8)]; w[1:0] = 2'($urandom_range(0, 2)); end
        if (s == 0) w[31:25] = 7'h00;
        else if (s == 1) w[31:25] = 7'h20;
        else if (s == 2) w[31:25] = 7'h01;
        return w;
    endfunction

    // acceptor: records what the DUT takes in, just after the sampling point
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back(model(in_inst, in_pc));
        end
    end

    // monitor: handshake state against the scoreboard depth, bundle against the head
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("m0_out_valid", 32'(m0_out_valid), 32'(q.size() != 0));
            if (out_valid && out_ready && !flush) begin
                if (q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_output: pc 0x%08h with empty scoreboard", out_pc);
                end else begin
                    me = q.pop_front();
                    chk("out_pc", out_pc, me.pc);
                    chk("illegal", 32'(illegal), 32'(me.ill));
                    chk("rs1_addr", 32'(rs1_addr), 32'(me.rs1));
                    chk("rs2_addr", 32'(rs2_addr), 32'(me.rs2));
                    chk("rd_addr", 32'(rd_addr), 32'(me.rd));
                    chk("rs1_en", 32'(rs1_en), 32'(me.rs1_en));
                    chk("rs2_en", 32'(rs2_en), 32'(me.rs2_en));
                    chk("rd_en", 32'(rd_en), 32'(me.rd_en));
                    chk("b_is_imm", 32'(b_is_imm), 32'(me.b_imm));
                    chk("a_is_pc", 32'(a_is_pc), 32'(me.a_pc));
                    chk("ex_operation", 32'(ex_operation), me.ex);
                    chk("cmp_op", 32'(cmp_op), 32'(me.cmp));
                    chk("is_branch", 32'(is_branch), 32'(me.br));
                    chk("is_jal", 32'(is_jal), 32'(me.jal));
                    chk("is_jalr", 32'(is_jalr), 32'(me.jalr));
                    chk("rd_is_link", 32'(rd_is_link), 32'(me.link));
                    chk("is_load", 32'(is_load), 32'(me.ld));
                    chk("is_store", 32'(is_store), 32'(me.st));
                    chk("mem_size", 32'(mem_size), 32'(me.msz));
                    chk("mem_unsigned", 32'(mem_unsigned), 32'(me.mu));
                    if (!me.ill) chk("imm", imm, me.imm);
                    chk("m0_illegal", 32'(m0_illegal), 32'(me.m0_ill));
                    chk("m0_rd_en", 32'(m0_rd_en), 32'(me.m0_rd_en));
                    chk("m0_ex_operation", 32'(m0_ex_operation), me.m0_ex);
                end
            end
        end
    end

    task automatic send(input logic [31:0] i, input logic [31:0] p);
        int n = 0;
        in_valid = 1'b1; in_inst = i; in_pc = p;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for inst 0x%08h", i);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_m0_in_ready", 32'(m0_in_ready), 0);
        chk("rst_imm", imm, 0);
        chk("rst_ex_operation", 32'(ex_operation), 0);
        chk("rst_out_pc", out_pc, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        send(32'h00500093, 32'h100);
        chk("latency_out_valid", 32'(out_valid), 1);
        send(32'hFFC0A103, 32'h104);
        send(32'h008000EF, 32'h108);
        send(32'h022081B3, 32'h10C);
        send(32'h40B50533, 32'h110);
        send(32'h4015D593, 32'h114);
        send(32'hFE208EE3, 32'h118);
        send(32'h00000013, 32'h11C);
        idle(3);

        out_ready = 1'b0;
        send(32'h00A00113, 32'h200);
        send(32'h00B00193, 32'h204);
        chk("full_in_ready", 32'(in_ready), 0);
        fork
            send(32'h00C00213, 32'h208);
            begin idle(3); out_ready = 1'b1; end
        join
        idle(4);

        out_ready = 1'b0;
        send(32'h00100093, 32'h300);
        send(32'h00200093, 32'h304);
        in_valid = 1'b1; in_inst = 32'h00300093; in_pc = 32'h308; flush = 1'b1;
        idle(1);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 1);
        send(32'h00400093, 32'h30C);
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h310; flush = 1'b1;
        idle(1);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush1_out_valid", 32'(out_valid), 0);
        out_ready = 1'b1;
        idle(3);

        repeat (800) begin
            in_valid  = $urandom_range(0, 3) != 0;
            in_inst   = rand_inst();
            in_pc     = $urandom;
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 39) == 0;
            idle(1);
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        idle(4);

        out_ready = 1'b0;
        send(32'h00100113, 32'h400);
        send(32'h00200113, 32'h404);
        chk("pre_arst_out_valid", 32'(out_valid), 1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_in_ready", 32'(in_ready), 0);
        chk("arst_out_pc", out_pc, 0);
        chk("arst_rd_en", 32'(rd_en), 0);
        q.delete();
        idle(1);
        rst = 1'b0;
        out_ready = 1'b1;
        idle(1);
        chk("post_arst_out_valid", 32'(out_valid), 0);
        send(32'h0000A183, 32'h500);
        idle(4);
        chk("final_empty", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
